// File: rtl/uart_send_cfg.sv
// uart_send_cfg: configurable UART transmitter.
// Frames are start bit, DATA_BITS data bits (LSB first), an optional parity bit
// and STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks. The serial line
// is registered and idles high.
module uart_send_cfg #(
  parameter int CLKS_PER_BIT = 625,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ready,
  input  logic [DATA_BITS-1:0] payload,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  // Widths fall back to 1 so illegal values still elaborate far enough to
  // reach the parameter checks below.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST   = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST  = (STOP_BITS == 2);
  localparam bit            HAS_PARITY = (PARITY != 0);
  localparam bit            ODD_PARITY = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Elaboration-time parameter checks; illegal values are rejected, not clamped.
  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_send_cfg: CLKS_PER_BIT must be 2 or more");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_send_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
    $error("uart_send_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_send_cfg: STOP_BITS must be 1 or 2");
  end

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state logic; tx_d carries the line level for the bit being entered so
  // the registered tx changes exactly on bit boundaries.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (ready) begin
          shift_d    = payload;
          par_d      = ODD_PARITY ? ~(^payload) : (^payload);
          state_d    = S_START;
          baud_d     = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            if (HAS_PARITY) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            stop_idx_d = 1'b0;
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        baud_d     = '0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_send_cfg.sv
// Directed bench for uart_send_cfg: four instances (8N1, 8E1, 8O1, 7N2) at
// four clocks per bit share stimulus; sel chooses which one is observed.
module tb_uart_send_cfg;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] payload;
  logic [3:0] tx_w, busy_w, done_w;
  int         sel;
  logic       tx_m, busy_m, done_m;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  uart_send_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .ready(ready), .payload(payload),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_send_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .ready(ready), .payload(payload),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_send_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .ready(ready), .payload(payload),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_send_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .ready(ready), .payload(payload[6:0]),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  always_comb begin
    tx_m = tx_w[0]; busy_m = busy_w[0]; done_m = done_w[0];
    case (sel)
      1: begin tx_m = tx_w[1]; busy_m = busy_w[1]; done_m = done_w[1]; end
      2: begin tx_m = tx_w[2]; busy_m = busy_w[2]; done_m = done_w[2]; end
      3: begin tx_m = tx_w[3]; busy_m = busy_w[3]; done_m = done_w[3]; end
      default: ;
    endcase
  end

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse ready for one clock; returns on the first cycle the frame should be busy.
  task automatic start_frame(input logic [7:0] data);
    payload = data; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  // Record one line sample per bit while busy, flagging level changes inside a bit.
  task automatic capture_frame(output int cyc, output logic [63:0] line,
                               output bit glitch, output int early_done);
    cyc = 0; line = '0; glitch = 1'b0; early_done = 0;
    while (busy_m === 1'b1 && cyc < 200) begin
      if (cyc % CPB == 0) line[cyc / CPB] = tx_m;
      else if (tx_m !== line[cyc / CPB]) glitch = 1'b1;
      if (done_m === 1'b1) early_done++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc, ed; logic [63:0] line; bit g;
    sel = 0; rst = 1'b1; ready = 1'b1; payload = 8'h55;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_w !== 4'hF) begin n_bad++; $display("FAIL reset_tx got=%b exp=1111", tx_w); end
    n_cmp++; if (busy_w !== 4'h0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0000", busy_w); end
    n_cmp++; if (done_w !== 4'h0) begin n_bad++; $display("FAIL reset_done got=%b exp=0000", done_w); end
    rst = 1'b0;
    @(negedge clk);
    ready = 1'b0;
    n_cmp++; if (busy_m !== 1'b1) begin n_bad++; $display("FAIL first_accept_busy got=%b exp=1", busy_m); end
    n_cmp++; if (tx_m !== 1'b0) begin n_bad++; $display("FAIL first_accept_tx got=%b exp=0", tx_m); end
    capture_frame(cyc, line, g, ed);
    n_cmp++; if (cyc != 40) begin n_bad++; $display("FAIL first_frame_len got=%0d exp=40", cyc); end
    n_cmp++; if (line[15:0] !== 16'h02AA) begin n_bad++; $display("FAIL first_frame_bits got=%h exp=02aa", line[15:0]); end
  endtask

  task automatic test_frame(input string name, input int s, input logic [7:0] data,
                            input logic [15:0] exp_line, input int exp_cyc);
    int cyc, ed; logic [63:0] line; bit g;
    sel = s;
    do_reset();
    start_frame(data);
    capture_frame(cyc, line, g, ed);
    n_cmp++; if (cyc != exp_cyc) begin n_bad++; $display("FAIL %s busy_len got=%0d exp=%0d", name, cyc, exp_cyc); end
    n_cmp++; if (line[15:0] !== exp_line) begin n_bad++; $display("FAIL %s bits got=%h exp=%h", name, line[15:0], exp_line); end
    n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL %s glitch got=%b exp=0", name, g); end
    n_cmp++; if (ed != 0) begin n_bad++; $display("FAIL %s early_done got=%0d exp=0", name, ed); end
    n_cmp++; if (done_m !== 1'b1) begin n_bad++; $display("FAIL %s done_pulse got=%b exp=1", name, done_m); end
    n_cmp++; if (tx_m !== 1'b1) begin n_bad++; $display("FAIL %s idle_tx got=%b exp=1", name, tx_m); end
    @(negedge clk);
    n_cmp++; if (done_m !== 1'b0) begin n_bad++; $display("FAIL %s done_width got=%b exp=0", name, done_m); end
    n_cmp++; if (busy_m !== 1'b0) begin n_bad++; $display("FAIL %s idle_busy got=%b exp=0", name, busy_m); end
  endtask

  task automatic test_back_to_back();
    int c1, c2, e1, e2; logic [63:0] l1, l2; bit g1, g2;
    sel = 0;
    do_reset();
    payload = 8'hA5; ready = 1'b1;
    @(negedge clk);
    payload = 8'h3C;
    capture_frame(c1, l1, g1, e1);
    n_cmp++; if (done_m !== 1'b1) begin n_bad++; $display("FAIL b2b_done1 got=%b exp=1", done_m); end
    n_cmp++; if (tx_m !== 1'b1) begin n_bad++; $display("FAIL b2b_gap_tx got=%b exp=1", tx_m); end
    @(negedge clk);
    ready = 1'b0;
    n_cmp++; if (busy_m !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy got=%b exp=1", busy_m); end
    n_cmp++; if (tx_m !== 1'b0) begin n_bad++; $display("FAIL b2b_restart_tx got=%b exp=0", tx_m); end
    capture_frame(c2, l2, g2, e2);
    n_cmp++; if (c1 != 40) begin n_bad++; $display("FAIL b2b_len1 got=%0d exp=40", c1); end
    n_cmp++; if (l1[15:0] !== 16'h034A) begin n_bad++; $display("FAIL b2b_bits1 got=%h exp=034a", l1[15:0]); end
    n_cmp++; if (c2 != 40) begin n_bad++; $display("FAIL b2b_len2 got=%0d exp=40", c2); end
    n_cmp++; if (l2[15:0] !== 16'h0278) begin n_bad++; $display("FAIL b2b_bits2 got=%h exp=0278", l2[15:0]); end
    n_cmp++; if ((g1 | g2) !== 1'b0) begin n_bad++; $display("FAIL b2b_glitch got=%b exp=0", g1 | g2); end
    n_cmp++; if (done_m !== 1'b1) begin n_bad++; $display("FAIL b2b_done2 got=%b exp=1", done_m); end
  endtask

  task automatic test_reset_midframe();
    int cyc, ed, stray; logic [63:0] line; bit g;
    sel = 0;
    do_reset();
    start_frame(8'hF0);
    repeat (13) @(negedge clk);
    n_cmp++; if (tx_m !== 1'b0) begin n_bad++; $display("FAIL mid_data2_tx got=%b exp=0", tx_m); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_m !== 1'b1) begin n_bad++; $display("FAIL mid_rst_tx got=%b exp=1", tx_m); end
    n_cmp++; if (busy_m !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy_m); end
    n_cmp++; if (done_m !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done got=%b exp=0", done_m); end
    rst = 1'b0;
    stray = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_m !== 1'b0 || busy_m !== 1'b0 || tx_m !== 1'b1) stray++;
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL mid_after_rst_activity got=%0d exp=0", stray); end
    start_frame(8'h3C);
    capture_frame(cyc, line, g, ed);
    n_cmp++; if (cyc != 40) begin n_bad++; $display("FAIL mid_next_len got=%0d exp=40", cyc); end
    n_cmp++; if (line[15:0] !== 16'h0278) begin n_bad++; $display("FAIL mid_next_bits got=%h exp=0278", line[15:0]); end
    n_cmp++; if (done_m !== 1'b1) begin n_bad++; $display("FAIL mid_next_done got=%b exp=1", done_m); end
  endtask

  task automatic test_busy_ignore();
    int cyc, ed, extra; logic [63:0] line; bit g;
    sel = 0;
    do_reset();
    start_frame(8'h96);
    fork
      capture_frame(cyc, line, g, ed);
      begin
        repeat (10) @(negedge clk);
        payload = 8'hFF; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (5) @(negedge clk);
        payload = 8'h00;
      end
    join
    n_cmp++; if (cyc != 40) begin n_bad++; $display("FAIL ign_len got=%0d exp=40", cyc); end
    n_cmp++; if (line[15:0] !== 16'h032C) begin n_bad++; $display("FAIL ign_bits got=%h exp=032c", line[15:0]); end
    n_cmp++; if (done_m !== 1'b1) begin n_bad++; $display("FAIL ign_done got=%b exp=1", done_m); end
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy_m !== 1'b0) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL ign_extra_frame got=%0d exp=0", extra); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ready = 1'b0; payload = 8'h00; sel = 0;
    @(negedge clk);
    test_reset();
    test_frame("8n1_55", 0, 8'h55, 16'h02AA, 40);
    test_frame("8e1_07", 1, 8'h07, 16'h060E, 44);
    test_frame("8o1_07", 2, 8'h07, 16'h040E, 44);
    test_frame("7n2_41", 3, 8'h41, 16'h0382, 40);
    test_back_to_back();
    test_reset_midframe();
    test_busy_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
